note_tone_gen: RTL
==================

NOTE_TONE_GEN -- requirements
Module: note_tone_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 12: width of the half-period field, in clock cycles.
REQ-002 SHALL have parameter DUR_W, default 16: width of the duration field, in ticks.
REQ-003 SHALL have parameter TICK_CYCLES, default 40000: clock cycles per duration tick (1 ms at 40 MHz).
REQ-004 SHALL have port wb_clk_i  input  1: the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have port enable  input  1: run/pause control.
REQ-007 SHALL have port note_valid  input  1: a note request is present.
REQ-008 SHALL have port note_ready  output  1: the block can accept a request.
REQ-009 SHALL have port note_period  input  DIV_W: half-period in cycles; 0 means rest.
REQ-010 SHALL have port note_dur  input  DUR_W: note length in ticks.
REQ-011 SHALL have port audio_out  output  1: square-wave audio bit driven to the user I/O pin.
REQ-012 SHALL have port busy  output  1: a note is playing.
REQ-013 SHALL have port note_done  output  1: one-cycle pulse when a note ends.

Function
REQ-014 SHALL hold a one-deep pending buffer; note_ready = !pending_valid, driven from a register only.
REQ-015 SHALL accept a request on a clock edge where note_valid && note_ready, capturing period and dur into the buffer.
REQ-016 SHALL implement the states IDLE and PLAY; busy = (state == PLAY).
REQ-017 IDLE with the pending buffer full and enable=1 SHALL load the buffer on the next edge: state=PLAY, buffer cleared, half-counter=0, tick-counter=0, tone=1 (tone=0 for a rest).
REQ-018 In PLAY with enable=1, tone SHALL toggle every note_period cycles (half-counter counts 0..period-1, then wraps); a rest SHALL hold tone=0.
REQ-019 In PLAY the tick counter SHALL wrap every TICK_CYCLES cycles, decrementing the remaining duration; the note SHALL last exactly dur*TICK_CYCLES enabled cycles.
REQ-020 On the final cycle of a note, note_done SHALL pulse on the following cycle. If the buffer is full, the next note SHALL load on that same edge (gapless, busy stays 1); otherwise state=IDLE and tone=0.
REQ-021 A note with dur=0 SHALL be consumed without entering PLAY: note_done pulses once, audio_out stays 0.
REQ-022 audio_out SHALL equal tone && enable; it is registered tone gated by enable.
REQ-023 When enable=0, all counters and state SHALL freeze and no load SHALL occur; buffer acceptance SHALL continue.
REQ-024 The counter widths SHALL be sized for the maximum field values without overflow; period and dur SHALL be treated as unsigned.

Reset
REQ-025 While rst_n=0, the block SHALL be in state IDLE with: pending buffer empty, all counters 0, audio_out=0, busy=0, note_done=0, note_ready=1.
REQ-026 An asserted rst_n mid-note SHALL abort the playing note and drop the pending note; no note_done pulse SHALL be generated for either.
REQ-027 The first request SHALL be accepted on the first edge after rst_n deasserts.

Verification (TICK_CYCLES=4)
REQ-028 Reset check: assert rst_n=0 -> audio_out=0, busy=0, note_done=0, note_ready=1.
REQ-029 Single note: period=3, dur=2, enable=1 -> audio_out H,H,H,L,L,L,H,H for 8 cycles, then note_done for 1 cycle, busy=0, audio_out=0.
REQ-030 Back-to-back notes: send (3,2) then (2,1) while the first plays -> note_ready=0 until the second note loads; the second note follows with no gap (H,H,L,L); busy continuous for 12 cycles; two note_done pulses.
REQ-031 Rest and zero duration: (0,1) -> busy=1 and audio_out=0 for 4 cycles; (5,0) -> note_done pulse, busy stays 0.
REQ-032 Pause: enable=0 for 5 cycles in the middle of a (3,2) note -> audio_out=0 while paused, the waveform resumes where it left off, and note_done is delayed by 5 cycles.
REQ-033 Reset mid-note: rst_n=0 at cycle 4 of (3,2) with a pending note -> immediate IDLE state, buffer empty, no note_done pulse.

Source files
------------

// File: rtl/note_tone_gen.sv
// Square-wave note player: a one-deep request buffer feeds an IDLE/PLAY engine
// that toggles audio_out every note_period cycles for note_dur ticks.
module note_tone_gen #(
    parameter int unsigned DIV_W       = 12,
    parameter int unsigned DUR_W       = 16,
    parameter int unsigned TICK_CYCLES = 40000
) (
    input  logic             wb_clk_i,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [DIV_W-1:0] note_period,
    input  logic [DUR_W-1:0] note_dur,
    output logic             audio_out,
    output logic             busy,
    output logic             note_done
);

    localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t              state_q, state_d;
    logic                pend_empty_q, pend_empty_d;
    logic [DIV_W-1:0]    pend_period_q, pend_period_d;
    logic [DUR_W-1:0]    pend_dur_q, pend_dur_d;
    logic [DIV_W-1:0]    cur_period_q, cur_period_d;
    logic [DUR_W-1:0]    dur_left_q, dur_left_d;
    logic [DIV_W-1:0]    half_cnt_q, half_cnt_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic                tone_q, tone_d;
    logic                done_q, done_d;
    logic                load;

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pend_empty_q  <= 1'b1;
            pend_period_q <= '0;
            pend_dur_q    <= '0;
            cur_period_q  <= '0;
            dur_left_q    <= '0;
            half_cnt_q    <= '0;
            tick_cnt_q    <= '0;
            tone_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_empty_q  <= pend_empty_d;
            pend_period_q <= pend_period_d;
            pend_dur_q    <= pend_dur_d;
            cur_period_q  <= cur_period_d;
            dur_left_q    <= dur_left_d;
            half_cnt_q    <= half_cnt_d;
            tick_cnt_q    <= tick_cnt_d;
            tone_q        <= tone_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_empty_d  = pend_empty_q;
        pend_period_d = pend_period_q;
        pend_dur_d    = pend_dur_q;
        cur_period_d  = cur_period_q;
        dur_left_d    = dur_left_q;
        half_cnt_d    = half_cnt_q;
        tick_cnt_d    = tick_cnt_q;
        tone_d        = tone_q;
        done_d        = 1'b0;
        load          = 1'b0;

        if (enable) begin
            case (state_q)
                IDLE: load = !pend_empty_q;
                PLAY: begin
                    if (cur_period_q != '0) begin
                        if (half_cnt_q == cur_period_q - DIV_W'(1)) begin
                            half_cnt_d = '0;
                            tone_d     = !tone_q;
                        end else begin
                            half_cnt_d = half_cnt_q + DIV_W'(1);
                        end
                    end
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        if (dur_left_q == DUR_W'(1)) begin
                            done_d = 1'b1;
                            // A zero-length follower is left for IDLE to consume
                            if (!pend_empty_q && pend_dur_q != '0) begin
                                load = 1'b1;
                            end else begin
                                state_d = IDLE;
                                tone_d  = 1'b0;
                            end
                        end else begin
                            dur_left_d = dur_left_q - DUR_W'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (load) begin
            pend_empty_d = 1'b1;
            if (pend_dur_q == '0) begin
                done_d = 1'b1;
            end else begin
                state_d      = PLAY;
                cur_period_d = pend_period_q;
                dur_left_d   = pend_dur_q;
                half_cnt_d   = '0;
                tick_cnt_d   = '0;
                tone_d       = (pend_period_q != '0);
            end
        end

        // Acceptance only happens into an empty buffer, so it never races a load
        if (note_valid && pend_empty_q) begin
            pend_empty_d  = 1'b0;
            pend_period_d = note_period;
            pend_dur_d    = note_dur;
        end
    end

    assign note_ready = pend_empty_q;
    assign busy       = (state_q == PLAY);
    assign note_done  = done_q;
    assign audio_out  = tone_q && enable;

endmodule
